// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, read-owner
// encoding and the starvation counter width.
package mem_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned WAIT_CNT_W     = 4;

  typedef enum logic {
    NONE = 1'b0,
    ACC  = 1'b1
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (fixed priority) and the
// boid accelerator, with a starvation counter that forces an accelerator slot.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  acc_valid,
  input  logic                  acc_wren,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_wdata,
  output logic                  acc_ready,
  output logic                  acc_rvalid,
  output logic [DATA_WIDTH-1:0] acc_rdata,
  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dataIn,
  input  logic [DATA_WIDTH-1:0] ram_dataOut
);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  rd_owner_e             rd_owner_q, rd_owner_d;
  logic                  wait_full;
  logic                  acc_win;

  // Grant, RAM mux and next-state; everything is forced quiet during reset.
  always_comb begin
    wait_full  = (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT));
    acc_win    = !reset && acc_valid && (!cpu_req || wait_full);

    acc_ready  = acc_win;
    cpu_stall  = !reset && cpu_req && acc_win;

    ram_addr   = acc_win ? acc_addr  : cpu_addr;
    ram_dataIn = acc_win ? acc_wdata : cpu_wdata;
    ram_wEn    = !reset && (acc_win ? acc_wren : (cpu_req && cpu_wren));

    acc_rvalid = !reset && (rd_owner_q == ACC);
    acc_rdata  = ram_dataOut;
    cpu_rdata  = ram_dataOut;

    wait_cnt_d = wait_cnt_q;
    if (acc_win || !acc_valid) begin
      wait_cnt_d = '0;
    end else if (cpu_req && !wait_full) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end

    rd_owner_d = (acc_win && !acc_wren) ? ACC : NONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rd_owner_q <= NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed scoreboard bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wren, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          acc_valid, acc_wren, acc_ready, acc_rvalid;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, acc_rdata;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn, ram_dataOut;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .acc_valid(acc_valid), .acc_wren(acc_wren), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_ready(acc_ready), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          acc_q[$];
  exp_t          cpu_q[$];
  int            errors = 0;
  int            checks = 0;
  int unsigned   cyc = 0;
  int            m_wait = 0;
  logic          m_last_g = 1'b0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Single-port RAM with one-cycle synchronous read.
  initial begin : ram_model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
    mem[12'h020] = 32'h1234_5678;
    forever begin
      @(posedge clk);
      ram_dataOut <= mem[ram_addr];
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One cycle: drive inputs after the edge, then predict and check at the falling edge.
  task automatic step(input logic rst, input logic c_req, input logic c_wr,
                      input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                      input logic a_val, input logic a_wr,
                      input logic [AW-1:0] a_addr, input logic [DW-1:0] a_wd);
    logic          g, exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    @(posedge clk);
    #1;
    reset = rst;
    cpu_req = c_req; cpu_wren = c_wr; cpu_addr = c_addr; cpu_wdata = c_wd;
    acc_valid = a_val; acc_wren = a_wr; acc_addr = a_addr; acc_wdata = a_wd;
    if (rst) begin
      acc_q.delete();
      cpu_q.delete();
    end
    @(negedge clk);
    if (rst) begin
      check("rst_acc_ready", 32'(acc_ready), 0);
      check("rst_cpu_stall", 32'(cpu_stall), 0);
      check("rst_ram_wEn", 32'(ram_wEn), 0);
      check("rst_acc_rvalid", 32'(acc_rvalid), 0);
      m_wait = 0;
      m_last_g = 1'b0;
    end else begin
      g = a_val && (!c_req || m_wait == MW);
      check("acc_ready", 32'(acc_ready), 32'(g));
      check("cpu_stall", 32'(cpu_stall), 32'(c_req && g));
      exp_we = g ? a_wr : (c_req && c_wr);
      exp_a  = g ? a_addr : c_addr;
      exp_d  = g ? a_wd : c_wd;
      check("ram_wEn", 32'(ram_wEn), 32'(exp_we));
      check("ram_addr", 32'(ram_addr), 32'(exp_a));
      if (exp_we) begin
        check("ram_dataIn", ram_dataIn, exp_d);
        ref_mem[exp_a] = exp_d;
      end else if (g) begin
        acc_q.push_back('{due: cyc + 1, data: ref_mem[a_addr]});
      end else if (c_req) begin
        cpu_q.push_back('{due: cyc + 1, data: ref_mem[c_addr]});
      end
      if (g || !a_val) m_wait = 0;
      else m_wait = m_wait + 1;
      m_last_g = g;
    end
  endtask

  // Read-data monitor: pops the scoreboard whenever a response is due or presented.
  initial begin : monitor
    logic exp_v;
    forever begin
      @(negedge clk);
      #1;
      while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
        check("acc_rvalid_missing", 1, 0);
        void'(acc_q.pop_front());
      end
      exp_v = (acc_q.size() > 0) && (acc_q[0].due == cyc);
      if (acc_rvalid || exp_v) check("acc_rvalid", 32'(acc_rvalid), 32'(exp_v));
      if (acc_rvalid && exp_v) check("acc_rdata", acc_rdata, acc_q[0].data);
      if (exp_v) void'(acc_q.pop_front());
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        check("cpu_rdata", cpu_rdata, cpu_q[0].data);
        void'(cpu_q.pop_front());
      end
    end
  end

  // Continuous CPU reads against one held accelerator request.
  task automatic starve(input logic [AW-1:0] aa, input logic aw, input logic [DW-1:0] ad,
                        input int ncyc);
    int   first = -1;
    int   pulses = 0;
    logic ap = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      step(0, 1, 0, AW'(1), '0, ap, aw, aa, ad);
      if (acc_ready) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (m_last_g) ap = 1'b0;
    end
    check("starve_grant_cycle", 32'(first), MW);
    check("acc_ready_pulses", 32'(pulses), 1);
  endtask

  initial begin : stimulus
    logic          ap, aw, cr, cw, c_hold, rst;
    logic [AW-1:0] aa, ca;
    logic [DW-1:0] ad, cd;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    ref_mem[12'h020] = 32'h1234_5678;
    reset = 1'b1;
    cpu_req = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
    acc_valid = 0; acc_wren = 0; acc_addr = '0; acc_wdata = '0;

    step(1, 1, 1, AW'(5), 32'h1, 1, 1, AW'(6), 32'h2);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);

    // CPU-only store then load.
    step(0, 1, 1, 12'h010, 32'hDEAD_BEEF, 0, 0, '0, '0);
    step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // Accelerator-only load of a preloaded word.
    step(0, 0, 0, '0, '0, 1, 0, 12'h020, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    starve(AW'(2), 0, '0, 6);

    // Same-address collision at the forced-grant boundary.
    for (int k = 0; k < int'(MW); k++) step(0, 1, 0, AW'(3), '0, 1, 1, 12'h030, 32'h5555);
    step(0, 1, 1, 12'h030, 32'hAAAA, 1, 1, 12'h030, 32'h5555);
    step(0, 1, 1, 12'h030, 32'hAAAA, 0, 0, '0, '0);
    step(0, 1, 0, 12'h030, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // Reset lands while an accelerator read is in flight.
    step(0, 0, 0, '0, '0, 1, 0, AW'(5), '0);
    step(1, 1, 0, AW'(4), '0, 0, 0, '0, '0);
    starve(AW'(7), 0, '0, 6);
    starve(AW'(8), 1, 32'hCAFE_F00D, 6);

    ap = 0; aw = 0; aa = '0; ad = '0; cr = 0; cw = 0; ca = '0; cd = '0; c_hold = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(79) == 0);
      if (!ap && $urandom_range(2) != 0) begin
        ap = 1; aw = 1'($urandom_range(1)); aa = AW'($urandom_range(15)); ad = $urandom;
      end
      if (!c_hold) begin
        cr = ($urandom_range(9) < 7); cw = 1'($urandom_range(1));
        ca = AW'($urandom_range(15)); cd = $urandom;
      end
      step(rst, cr, cw, ca, cd, ap, aw, aa, ad);
      if (!rst && m_last_g) ap = 0;
      c_hold = !rst && cr && m_last_g;
    end

    for (int k = 0; k < 3; k++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    check("acc_q_drained", 32'(acc_q.size()), 0);
    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
